// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the E stage.
// Holds busy for a fixed latency per operation class, then writes HI/LO.
// MTHI/MTLO update HI/LO directly in a single cycle without asserting busy.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e        state;
  logic [CW-1:0] count;
  op_e           op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          busy_r;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          div_ovf;
  logic [31:0]   b_safe;
  logic [31:0]   quo_s;
  logic [31:0]   rem_s;
  logic [31:0]   quo_u;
  logic [31:0]   rem_u;

  logic          res_we;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

  // Arithmetic datapath on the latched operands.
  // The divisor is forced to 1 for divide-by-zero and signed overflow so the
  // dividers never see an undefined case; those results are replaced below.
  assign prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u  = {32'b0, a_q} * {32'b0, b_q};
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == '1);
  assign b_safe  = ((b_q == '0) || div_ovf) ? 32'd1 : b_q;
  assign quo_s   = $signed(a_q) / $signed(b_safe);
  assign rem_s   = $signed(a_q) % $signed(b_safe);
  assign quo_u   = a_q / b_safe;
  assign rem_u   = a_q % b_safe;

  // Select the HI/LO write-back for the in-flight operation.
  always_comb begin
    res_we = 1'b0;
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      OP_MULT: begin
        res_we = 1'b1;
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_we = 1'b1;
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (b_q != '0) begin
          res_we = 1'b1;
          if (div_ovf) begin
            res_lo = 32'h8000_0000;
            res_hi = '0;
          end else begin
            res_lo = quo_s;
            res_hi = rem_s;
          end
        end
      end
      OP_DIVU: begin
        if (b_q != '0) begin
          res_we = 1'b1;
          res_lo = quo_u;
          res_hi = rem_u;
        end
      end
      default: ;
    endcase
  end

  // Control FSM: issue in IDLE, count down in BUSY, write back on the last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      op_q   <= OP_NONE;
      a_q    <= '0;
      b_q    <= '0;
      busy_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op_e'(MDUOp))
              OP_MULT, OP_MULTU: begin
                op_q   <= op_e'(MDUOp);
                a_q    <= A;
                b_q    <= B;
                count  <= MULT_LOAD;
                busy_r <= 1'b1;
                state  <= BUSY;
              end
              OP_DIV, OP_DIVU: begin
                op_q   <= op_e'(MDUOp);
                a_q    <= A;
                b_q    <= B;
                count  <= DIV_LOAD;
                busy_r <= 1'b1;
                state  <= BUSY;
              end
              OP_MTHI: hi_r <= A;
              OP_MTLO: lo_r <= A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            busy_r <= 1'b0;
            state  <= IDLE;
            if (res_we) begin
              hi_r <= res_hi;
              lo_r <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
